// File: rtl/onewire_master_ctrl.sv
// onewire_master_ctrl: 1-Wire bus initiator.
// Reset/presence, bit and byte write/read slots on an open-drain line.
module onewire_master_ctrl #(
  parameter int CLK_PER_US = 50,
  parameter int T_RSTL     = 480,
  parameter int T_PDS      = 70,
  parameter int T_RSTH     = 480,
  parameter int T_SLOT     = 60,
  parameter int T_LOW1     = 6,
  parameter int T_RDS      = 15,
  parameter int T_REC      = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] cmd,
  input  logic       cmd_valid,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic [7:0] status,
  inout  wire        onewire_bus
);

  localparam int PW = $clog2(CLK_PER_US);
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_US - 1);

  localparam logic [9:0] RSTL_M1 = 10'(T_RSTL - 1);
  localparam logic [9:0] PDS_M1  = 10'(T_PDS - 1);
  localparam logic [9:0] RSTH_M1 = 10'(T_RSTH - T_PDS - 1);
  localparam logic [9:0] LOW1_M1 = 10'(T_LOW1 - 1);
  localparam logic [9:0] SLOT_M1 = 10'(T_SLOT - 1);
  localparam logic [9:0] REL_M1  = 10'(T_SLOT - T_LOW1 - 1);
  localparam logic [9:0] RDS_M1  = 10'(T_RDS - T_LOW1 - 1);
  localparam logic [9:0] REC_M1  = 10'(T_REC - 1);

  typedef enum logic [2:0] {
    IDLE,
    RST_LOW,
    RST_REL,
    RST_RECOV,
    SLOT_LOW,
    SLOT_REL,
    SLOT_RECOV,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q;
  logic [9:0]    us_q;
  logic [2:0]    cmd_q;
  logic [7:0]    shreg_q;
  logic [3:0]    cnt_q;
  logic          drive_q;
  logic          busy_q;
  logic          pres_q;
  logic          done_q;
  logic          err_q;
  logic [7:0]    dout_q;
  logic          sync1_q, sync2_q;

  logic       us_tick, expire, rd_hit;
  logic       is_rd, is_byte, wr0, accept;
  logic [9:0] tgt;

  assign onewire_bus = drive_q ? 1'b0 : 1'bz;

  assign data_out = dout_q;
  assign status   = {4'b0, err_q, done_q, pres_q, busy_q};

  assign us_tick = (pre_q == PRE_MAX);
  assign is_rd   = (cmd_q == 3'b011) || (cmd_q == 3'b101);
  assign is_byte = (cmd_q == 3'b010) || (cmd_q == 3'b011);
  assign wr0     = !is_rd && !shreg_q[0];
  assign accept  = (state_q == IDLE) && cmd_valid && !busy_q
                && (cmd != 3'b000) && (cmd < 3'b110);
  assign expire  = us_tick && (us_q == tgt);
  assign rd_hit  = us_tick && (us_q == RDS_M1);

  always_comb begin
    tgt = '0;
    case (state_q)
      RST_LOW:    tgt = RSTL_M1;
      RST_REL:    tgt = PDS_M1;
      RST_RECOV:  tgt = RSTH_M1;
      SLOT_LOW:   tgt = wr0 ? SLOT_M1 : LOW1_M1;
      SLOT_REL:   tgt = REL_M1;
      SLOT_RECOV: tgt = REC_M1;
      default:    tgt = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:
        if (accept)
          state_d = (cmd == 3'b001) ? RST_LOW : SLOT_LOW;
      RST_LOW:   if (expire) state_d = RST_REL;
      RST_REL:   if (expire) state_d = RST_RECOV;
      RST_RECOV: if (expire) state_d = DONE;
      // a write-0 holds the line for the whole slot, so no release phase
      SLOT_LOW:
        if (expire)
          state_d = wr0 ? SLOT_RECOV : SLOT_REL;
      SLOT_REL:  if (expire) state_d = SLOT_RECOV;
      SLOT_RECOV:
        if (expire)
          state_d = (cnt_q == 4'd1) ? DONE : SLOT_LOW;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= onewire_bus;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
      us_q  <= '0;
    end else if (state_d != state_q) begin
      pre_q <= '0;
      us_q  <= '0;
    end else begin
      pre_q <= us_tick ? '0 : pre_q + 1'b1;
      us_q  <= us_q + {9'd0, us_tick};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
      drive_q <= 1'b0;
      busy_q  <= 1'b0;
      pres_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE:
          if (accept) begin
            cmd_q   <= cmd;
            shreg_q <= data_in;
            cnt_q   <= (cmd == 3'b010 || cmd == 3'b011) ? 4'd8 : 4'd1;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            drive_q <= 1'b1;
          end
        RST_LOW:
          if (expire) drive_q <= 1'b0;
        RST_REL:
          if (expire) pres_q <= ~sync2_q;
        RST_RECOV:
          if (expire) err_q <= err_q | ~sync2_q;
        SLOT_LOW:
          if (expire) drive_q <= 1'b0;
        SLOT_REL:
          if (is_rd && rd_hit)
            shreg_q <= {sync2_q, shreg_q[7:1]};
        SLOT_RECOV:
          if (expire) begin
            err_q <= err_q | ~sync2_q;
            cnt_q <= cnt_q - 4'd1;
            if (!is_rd) shreg_q <= {1'b0, shreg_q[7:1]};
            if (cnt_q != 4'd1) drive_q <= 1'b1;
          end
        DONE: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          if (is_rd)
            dout_q <= is_byte ? shreg_q : {7'd0, shreg_q[7]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_onewire_master_ctrl.sv
// tb_onewire_master_ctrl: directed bench with a behavioural 1-Wire slave.
// Expected status/data are queued per command and checked on the done pulse.
`timescale 1ns/1ps
module tb_onewire_master_ctrl;

  localparam int US = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic [7:0] status;
  wire        ow;
  logic       slv_low;
  logic       ext_low;

  pullup (ow);
  assign ow = (slv_low || ext_low) ? 1'b0 : 1'bz;

  onewire_master_ctrl #(.CLK_PER_US(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .data_in    (data_in),
    .data_out   (data_out),
    .status     (status),
    .onewire_bus(ow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [7:0] dout;
    logic [7:0] stat;
  } exp_t;

  exp_t       sb[$];
  time        wq[$];
  time        t0;
  int         slv_mode;
  int         rd_idx;
  logic [7:0] rd_byte;
  logic [7:0] wbyte;

  // slave: 1 = presence responder, 2 = write-slot sampler, 3 = read responder
  initial begin
    slv_low = 1'b0;
    forever begin
      @(negedge ow);
      t0 = $time;
      case (slv_mode)
        1: begin
          @(posedge ow);
          #(30 * US);
          slv_low = 1'b1;
          #(120 * US);
          slv_low = 1'b0;
        end
        2: begin
          @(posedge ow);
          wq.push_back($time - t0);
        end
        3: begin
          if (!rd_byte[rd_idx[2:0]]) begin
            slv_low = 1'b1;
            #(30 * US);
            slv_low = 1'b0;
          end
          rd_idx++;
        end
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input logic [2:0] c,
                     input logic [7:0] d, input logic [7:0] exp_dout,
                     input logic pres, input logic err,
                     input int exp_cyc, input bit inject);
    int   n;
    exp_t e;
    e.dout = exp_dout;
    e.stat = {4'b0, err, 1'b1, pres, 1'b0};
    sb.push_back(e);
    cmd       = c;
    data_in   = d;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd       = 3'b000;
    chk({tag, "_busy"}, 32'(status[0]), 32'd1);
    n = 0;
    while (!status[2] && n < 20000) begin
      if (inject && n == 50) begin
        cmd       = 3'b010;
        data_in   = 8'hFF;
        cmd_valid = 1'b1;
      end else if (inject && n == 51) begin
        cmd_valid = 1'b0;
        cmd       = 3'b000;
      end
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 32'(status[2]), 32'd1);
    if (exp_cyc > 0) chk({tag, "_cycles"}, 32'(n), 32'(exp_cyc));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_status"}, 32'(status), 32'(e.stat));
      chk({tag, "_dout"}, 32'(data_out), 32'(e.dout));
    end
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(status[2]), 32'd0);
    chk({tag, "_idle"}, 32'(status[0]), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    cmd       = 3'b000;
    cmd_valid = 1'b0;
    data_in   = 8'h00;
    ext_low   = 1'b0;
    slv_mode  = 0;
    rd_idx    = 0;
    rd_byte   = 8'h00;
    wbyte     = 8'hA5;

    repeat (3) @(negedge clk);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);
    chk("rst_bus", 32'(ow), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_status", 32'(status), 32'd0);

    slv_mode = 1;
    run("reset_slave", 3'b001, 8'h00, 8'h00, 1'b1, 1'b0, 3841, 1'b0);
    slv_mode = 0;
    run("reset_none", 3'b001, 8'h00, 8'h00, 1'b0, 1'b0, 3841, 1'b0);

    slv_mode = 3;
    rd_byte  = 8'h3C;
    rd_idx   = 0;
    run("read_byte", 3'b011, 8'h00, 8'h3C, 1'b0, 1'b0, 0, 1'b1);
    chk("read_slots", 32'(rd_idx), 32'd8);

    slv_mode = 2;
    wq.delete();
    run("write_byte", 3'b010, 8'hA5, 8'h3C, 1'b0, 1'b0, 0, 1'b0);
    chk("write_slots", 32'(wq.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      chk("write_width", 32'(wq[i]), wbyte[i] ? 32'd240 : 32'd2400);

    slv_mode = 3;
    rd_byte  = 8'hFF;
    rd_idx   = 0;
    run("read_bit1", 3'b101, 8'h00, 8'h01, 1'b0, 1'b0, 0, 1'b0);

    slv_mode = 0;
    ext_low  = 1'b1;
    run("bus_stuck", 3'b100, 8'h01, 8'h01, 1'b0, 1'b1, 0, 1'b0);
    ext_low  = 1'b0;

    cmd_valid = 1'b1;
    cmd       = 3'b000;
    @(negedge clk);
    cmd       = 3'b110;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd       = 3'b000;
    @(negedge clk);
    chk("nop_ignored", 32'(status), 32'h08);

    slv_mode = 2;
    wq.delete();
    run("write_bit0", 3'b100, 8'hFE, 8'h01, 1'b0, 1'b0, 0, 1'b0);
    chk("wbit_slots", 32'(wq.size()), 32'd1);
    chk("wbit_width", 32'(wq[0]), 32'd2400);

    slv_mode  = 0;
    cmd       = 3'b010;
    data_in   = 8'h00;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd       = 3'b000;
    repeat (10) @(negedge clk);
    chk("abort_driving", 32'(ow), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("abort_bus", 32'(ow), 32'd1);
    chk("abort_status", 32'(status), 32'd0);
    chk("abort_dout", 32'(data_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_idle", 32'(status), 32'd0);

    slv_mode = 3;
    rd_byte  = 8'hFF;
    rd_idx   = 0;
    run("post_abort", 3'b101, 8'h00, 8'h01, 1'b0, 1'b0, 0, 1'b0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
